busca_instrucao: RTL and testbench

Instruction-fetch stage directly downstream of the 16-bit program counter. Each cycle it may present the counter's current value to a synchronous instruction memory, and it pulses the counter's increment input (`soma`) on every issued read. It buffers returned words with their PC in a small FIFO and hands them to the decode stage over a valid/ready handshake. On a branch redirect it loads the target through the counter's load port (`carregar`/`entrada`) and discards stale fetches.

---
 rtl/pacote_busca.sv | 17 +
 rtl/fila_instrucao.sv | 62 ++++++
 rtl/busca_instrucao.sv | 99 +++++++++
 tb/tb_busca_instrucao.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_busca.sv
// busca_instrucao shared types: default width, FSM states, FIFO entry.
// Imported by the fetch top level and its instruction FIFO.
package pacote_busca;

  localparam int LARGURA_PADRAO = 16;

  typedef enum logic {
    PARADO   = 1'b0,
    BUSCANDO = 1'b1
  } estado_t;

  typedef struct packed {
    logic [LARGURA_PADRAO-1:0] dado;
    logic [LARGURA_PADRAO-1:0] pc;
  } entrada_t;

endpackage

// File: rtl/fila_instrucao.sv
// Circular FIFO of fetched {instruction, pc} pairs.
// Flush wins over a same-cycle push; a pop with flush is simply absorbed.
module fila_instrucao
  import pacote_busca::*;
#(
  parameter  int PROFUNDIDADE = 3,
  localparam int CW = $clog2(PROFUNDIDADE + 1),
  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
  input  logic          relogio,
  input  logic          reiniciar_n,
  input  logic          empurrar,
  input  entrada_t      entrada,
  input  logic          retirar,
  input  logic          limpar,
  output entrada_t      cabeca,
  output logic          valida,
  output logic [CW-1:0] ocupacao
);

  entrada_t      mem [PROFUNDIDADE];
  logic [PW-1:0] ptr_esc;
  logic [PW-1:0] ptr_lei;
  logic          cheia;
  logic          entra;
  logic          sai;

  function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
    return (p == PW'(PROFUNDIDADE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valida = (ocupacao != '0);
  assign cheia  = (ocupacao == CW'(PROFUNDIDADE));
  assign sai    = retirar & valida;
  assign entra  = empurrar & ~limpar & (~cheia | sai);
  assign cabeca = mem[ptr_lei];

  always_ff @(posedge relogio or negedge reiniciar_n) begin
    if (!reiniciar_n) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      ocupacao <= '0;
    end else if (limpar) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      ocupacao <= '0;
    end else begin
      if (entra) ptr_esc <= avanca(ptr_esc);
      if (sai)   ptr_lei <= avanca(ptr_lei);
      ocupacao <= ocupacao + CW'(entra) - CW'(sai);
    end
  end

  always_ff @(posedge relogio or negedge reiniciar_n) begin
    if (!reiniciar_n) begin
      for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
    end else if (entra) begin
      mem[ptr_esc] <= entrada;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: drives the PC counter and a 1-cycle memory,
// buffers returned words and hands them to decode via valid/ready.
module busca_instrucao
  import pacote_busca::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = 3
) (
  input  logic               relogio,
  input  logic               reiniciar_n,
  input  logic               habilitar,
  input  logic [LARGURA-1:0] pc_atual,
  output logic               pc_soma,
  output logic               pc_carregar,
  output logic [LARGURA-1:0] pc_entrada,
  input  logic               desvio_valido,
  input  logic [LARGURA-1:0] desvio_alvo,
  output logic               mem_ler,
  output logic [LARGURA-1:0] mem_endereco,
  input  logic [LARGURA-1:0] mem_dado,
  output logic               instr_valida,
  output logic [LARGURA-1:0] instr_dado,
  output logic [LARGURA-1:0] instr_pc,
  input  logic               instr_pronta
);

  localparam int CW = $clog2(PROFUNDIDADE + 1);

  estado_t            estado;
  estado_t            proximo;
  logic               emitir;
  logic               folga;
  logic               morto;
  logic               em_voo;
  logic [LARGURA-1:0] pc_voo;
  logic               empurrar;
  logic               valida;
  logic [CW-1:0]      ocupacao;
  entrada_t           entrada;
  entrada_t           cabeca;

  always_ff @(posedge relogio or negedge reiniciar_n) begin
    if (!reiniciar_n) estado <= PARADO;
    else              estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    unique case (estado)
      PARADO:   if (habilitar)  proximo = BUSCANDO;
      BUSCANDO: if (!habilitar) proximo = PARADO;
    endcase
  end

  // Dropping habilitar stops issue in that very cycle, not one later.
  always_comb begin
    folga  = (int'(ocupacao) + int'(em_voo)) < PROFUNDIDADE;
    emitir = (estado == BUSCANDO) & habilitar & ~desvio_valido & folga;
    mem_ler      = emitir;
    pc_soma      = emitir;
    mem_endereco = emitir ? pc_atual : '0;
    pc_carregar  = desvio_valido;
    pc_entrada   = desvio_valido ? desvio_alvo : '0;
  end

  // The word on mem_dado during a redirect belongs to the old path.
  assign morto    = desvio_valido;
  assign empurrar = em_voo & ~morto;
  assign entrada  = '{dado: mem_dado, pc: pc_voo};

  always_ff @(posedge relogio or negedge reiniciar_n) begin
    if (!reiniciar_n) begin
      em_voo <= 1'b0;
      pc_voo <= '0;
    end else begin
      em_voo <= emitir;
      if (emitir) pc_voo <= pc_atual;
    end
  end

  fila_instrucao #(
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fila (
    .relogio    (relogio),
    .reiniciar_n(reiniciar_n),
    .empurrar   (empurrar),
    .entrada    (entrada),
    .retirar    (instr_pronta),
    .limpar     (desvio_valido),
    .cabeca     (cabeca),
    .valida     (valida),
    .ocupacao   (ocupacao)
  );

  assign instr_valida = valida;
  assign instr_dado   = valida ? cabeca.dado : '0;
  assign instr_pc     = valida ? cabeca.pc   : '0;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: counter + memory models, directed table,
// reset sequence and random traffic against a queue-based reference.
module tb_busca_instrucao;

  localparam logic S = 1'b1;
  localparam logic N = 1'b0;

  logic        relogio = 1'b0;
  logic        reiniciar_n;
  logic        habilitar;
  logic        desvio_valido;
  logic        instr_pronta;
  logic [15:0] desvio_alvo;
  logic [15:0] pc_atual;
  logic [15:0] pc_entrada;
  logic [15:0] mem_endereco;
  logic [15:0] mem_dado;
  logic [15:0] instr_dado;
  logic [15:0] instr_pc;
  logic        pc_soma;
  logic        pc_carregar;
  logic        mem_ler;
  logic        instr_valida;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  busca_instrucao dut (
    .relogio      (relogio),
    .reiniciar_n  (reiniciar_n),
    .habilitar    (habilitar),
    .pc_atual     (pc_atual),
    .pc_soma      (pc_soma),
    .pc_carregar  (pc_carregar),
    .pc_entrada   (pc_entrada),
    .desvio_valido(desvio_valido),
    .desvio_alvo  (desvio_alvo),
    .mem_ler      (mem_ler),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .instr_valida (instr_valida),
    .instr_dado   (instr_dado),
    .instr_pc     (instr_pc),
    .instr_pronta (instr_pronta)
  );

  always #5 relogio = ~relogio;

  // Program counter: reset together with the fetch stage.
  always @(posedge relogio or negedge reiniciar_n) begin
    if (!reiniciar_n)     pc_atual <= 16'h0000;
    else if (pc_carregar) pc_atual <= pc_entrada;
    else if (pc_soma)     pc_atual <= pc_atual + 16'd1;
  end

  // Memory: addr ^ A5A5 exactly one cycle after the read; junk otherwise.
  always @(posedge relogio)
    mem_dado <= mem_ler ? (mem_endereco ^ 16'hA5A5) : 16'hDEAD;

  // Reference: every issued fetch is a {pc, issue cycle} entry in order.
  typedef struct {
    logic [15:0] pc;
    int          t;
  } busca_t;

  busca_t      fila[$];
  logic [15:0] prox_pc;
  logic        rodando;
  logic        e_ler;
  logic        e_val;

  typedef struct {
    logic        hab;
    logic        pronta;
    logic        desvio;
    logic [15:0] alvo;
    logic        ler;
    logic [15:0] addr;
    logic        val;
    logic [15:0] pc;
  } vetor_t;

  vetor_t tab [27];

  function automatic vetor_t v(
    input logic h, input logic p, input logic d, input logic [15:0] a,
    input logic l, input logic [15:0] ad,
    input logic vl, input logic [15:0] pc
  );
    vetor_t r;
    r.hab = h; r.pronta = p; r.desvio = d; r.alvo = a;
    r.ler = l; r.addr = ad; r.val = vl; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string nome, input logic [31:0] obtido,
                     input logic [31:0] esperado);
    checks++;
    if (obtido !== esperado) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h cycle=%0d",
               nome, obtido, esperado, cyc);
    end
  endtask

  task automatic model_reset();
    fila.delete();
    prox_pc = 16'h0000;
    rodando = 1'b0;
  endtask

  task automatic model_check();
    logic [15:0] e_pc;
    logic [15:0] e_dado;
    e_ler = rodando && habilitar && !desvio_valido && (fila.size() < 3);
    e_val = (fila.size() > 0) && (fila[0].t + 2 <= cyc);
    e_pc   = 16'h0000;
    e_dado = 16'h0000;
    if (e_val) begin
      e_pc   = fila[0].pc;
      e_dado = fila[0].pc ^ 16'hA5A5;
    end
    chk("ler", mem_ler, e_ler);
    chk("soma", pc_soma, e_ler);
    chk("carregar", pc_carregar, desvio_valido);
    chk("endereco", mem_endereco, e_ler ? prox_pc : 16'h0000);
    chk("entrada", pc_entrada, desvio_valido ? desvio_alvo : 16'h0000);
    chk("valida", instr_valida, e_val);
    chk("pc", instr_pc, e_pc);
    chk("dado", instr_dado, e_dado);
  endtask

  task automatic model_update();
    if (e_val && instr_pronta) void'(fila.pop_front());
    if (desvio_valido) begin
      fila.delete();
      prox_pc = desvio_alvo;
    end else if (e_ler) begin
      fila.push_back(busca_t'{pc: prox_pc, t: cyc});
      prox_pc = prox_pc + 16'd1;
    end
    rodando = habilitar;
    cyc++;
  endtask

  task automatic aplica(input logic h, input logic p, input logic d,
                        input logic [15:0] a);
    habilitar     = h;
    instr_pronta  = p;
    desvio_valido = d;
    desvio_alvo   = a;
    @(negedge relogio);
    model_check();
  endtask

  task automatic avanca();
    @(posedge relogio);
    model_update();
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ler"}, mem_ler, 0);
    chk({tag, "_soma"}, pc_soma, 0);
    chk({tag, "_carregar"}, pc_carregar, 0);
    chk({tag, "_valida"}, instr_valida, 0);
    chk({tag, "_entrada"}, pc_entrada, 0);
    chk({tag, "_endereco"}, mem_endereco, 0);
    chk({tag, "_dado"}, instr_dado, 0);
    chk({tag, "_pc"}, instr_pc, 0);
  endtask

  // Called at posedge+1; asserts reset mid-cycle, holds it over one edge.
  task automatic pulso_reset();
    desvio_valido = 1'b0;
    #2 reiniciar_n = 1'b0;
    #1 chk_zero("rst_async");
    model_reset();
    @(posedge relogio);
    #1 reiniciar_n = 1'b1;
  endtask

  initial begin
    reiniciar_n   = 1'b0;
    habilitar     = 1'b0;
    instr_pronta  = 1'b0;
    desvio_valido = 1'b0;
    desvio_alvo   = 16'h0000;
    model_reset();
    #3 chk_zero("reset");
    @(posedge relogio);
    #1 reiniciar_n = 1'b1;

    // Stall 6 cycles, drain, redirect to 0100, redirect to FFFE, halt.
    tab[0]  = v(S,N,N,16'h0000, N,16'h0000, N,16'h0000);
    tab[1]  = v(S,N,N,16'h0000, S,16'h0000, N,16'h0000);
    tab[2]  = v(S,N,N,16'h0000, S,16'h0001, N,16'h0000);
    tab[3]  = v(S,N,N,16'h0000, S,16'h0002, S,16'h0000);
    tab[4]  = v(S,N,N,16'h0000, N,16'h0000, S,16'h0000);
    tab[5]  = v(S,N,N,16'h0000, N,16'h0000, S,16'h0000);
    tab[6]  = v(S,S,N,16'h0000, N,16'h0000, S,16'h0000);
    tab[7]  = v(S,S,N,16'h0000, S,16'h0003, S,16'h0001);
    tab[8]  = v(S,S,N,16'h0000, S,16'h0004, S,16'h0002);
    tab[9]  = v(S,S,N,16'h0000, S,16'h0005, S,16'h0003);
    tab[10] = v(S,S,N,16'h0000, S,16'h0006, S,16'h0004);
    tab[11] = v(S,S,S,16'h0100, N,16'h0000, S,16'h0005);
    tab[12] = v(S,S,N,16'h0000, S,16'h0100, N,16'h0000);
    tab[13] = v(S,S,N,16'h0000, S,16'h0101, N,16'h0000);
    tab[14] = v(S,S,N,16'h0000, S,16'h0102, S,16'h0100);
    tab[15] = v(S,S,N,16'h0000, S,16'h0103, S,16'h0101);
    tab[16] = v(S,S,S,16'hFFFE, N,16'h0000, S,16'h0102);
    tab[17] = v(S,S,N,16'h0000, S,16'hFFFE, N,16'h0000);
    tab[18] = v(S,S,N,16'h0000, S,16'hFFFF, N,16'h0000);
    tab[19] = v(S,S,N,16'h0000, S,16'h0000, S,16'hFFFE);
    tab[20] = v(S,S,N,16'h0000, S,16'h0001, S,16'hFFFF);
    tab[21] = v(S,S,N,16'h0000, S,16'h0002, S,16'h0000);
    tab[22] = v(N,S,N,16'h0000, N,16'h0000, S,16'h0001);
    tab[23] = v(N,S,N,16'h0000, N,16'h0000, S,16'h0002);
    tab[24] = v(N,S,N,16'h0000, N,16'h0000, N,16'h0000);
    tab[25] = v(S,S,N,16'h0000, N,16'h0000, N,16'h0000);
    tab[26] = v(S,S,N,16'h0000, S,16'h0003, N,16'h0000);

    for (int i = 0; i < 27; i++) begin
      aplica(tab[i].hab, tab[i].pronta, tab[i].desvio, tab[i].alvo);
      chk("tbl_ler", mem_ler, tab[i].ler);
      chk("tbl_soma", pc_soma, tab[i].ler);
      chk("tbl_carregar", pc_carregar, tab[i].desvio);
      chk("tbl_valida", instr_valida, tab[i].val);
      if (tab[i].ler) chk("tbl_endereco", mem_endereco, tab[i].addr);
      if (tab[i].val) begin
        chk("tbl_pc", instr_pc, tab[i].pc);
        chk("tbl_dado", instr_dado, tab[i].pc ^ 16'hA5A5);
      end
      avanca();
    end

    // Fill FIFO with 3 and 4, leave 5 in flight, then reset.
    aplica(S, N, N, 16'h0000); avanca();
    aplica(S, N, N, 16'h0000); avanca();
    chk("pre_rst_valida", instr_valida, 1);
    chk("pre_rst_pc", instr_pc, 16'h0003);
    pulso_reset();
    aplica(N, S, N, 16'h0000); avanca();
    chk("post_rst_valida", instr_valida, 0);
    aplica(N, S, N, 16'h0000); avanca();
    aplica(S, S, N, 16'h0000); avanca();
    aplica(S, S, N, 16'h0000);
    chk("restart_ler", mem_ler, 1);
    chk("restart_addr", mem_endereco, 16'h0000);
    avanca();

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] alvo;
      alvo = ($urandom_range(0, 3) == 0)
           ? 16'hFFFC + 16'($urandom_range(0, 5))
           : 16'($urandom);
      aplica(logic'($urandom_range(0, 9) != 0),
             logic'($urandom_range(0, 2) != 0),
             logic'($urandom_range(0, 11) == 0),
             alvo);
      avanca();
      if ($urandom_range(0, 299) == 0) pulso_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
